// File: rtl/register_bank_p.sv
// ============================================================================
//  Module      : register_bank_p
//  Description : General register file with working register W, synchronised
//                input ports, strobed output ports and a sticky write error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_bank_p #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NUM_GPR = 28,
    parameter int unsigned NUM_IN  = 2,
    parameter int unsigned NUM_OUT = 2,
    parameter int unsigned SEL_W   = 6,
    parameter int unsigned W_CODE  = 34
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic [SEL_W-1:0]            Sel_A,
    input  logic [SEL_W-1:0]            Sel_B,
    input  logic                        rd_en,
    input  logic [SEL_W-1:0]            Sel_C,
    input  logic [DATA_W-1:0]           Data_C,
    input  logic                        wr_en,
    input  logic                        MR,
    input  logic [DATA_W-1:0]           W_IN,
    input  logic [NUM_IN*DATA_W-1:0]    Input_Port,
    output logic [DATA_W-1:0]           Data_A,
    output logic [DATA_W-1:0]           Data_B,
    output logic [NUM_OUT*DATA_W-1:0]   Output_Port,
    output logic [DATA_W-1:0]           Working_Reg,
    output logic [NUM_OUT-1:0]          out_stb,
    output logic                        illegal_wr
);

    localparam int unsigned c_in_base  = NUM_GPR;
    localparam int unsigned c_out_base = NUM_GPR + NUM_IN;
    localparam int unsigned c_end      = c_out_base + NUM_OUT;
    localparam int unsigned c_codes    = 1 << SEL_W;
    localparam logic [SEL_W-1:0] c_w_sel = SEL_W'(W_CODE);

    if ((W_CODE >= c_codes) || (c_end > W_CODE)) begin : g_bad_params
        $error("register_bank_p: W_CODE must satisfy NUM_GPR+NUM_IN+NUM_OUT <= W_CODE < 2**SEL_W");
    end

    // Read table indexed directly by a select code; undefined codes read as 0.
    logic [DATA_W-1:0]  w_rd_tbl [c_codes];
    logic [c_codes-1:0] w_legal;
    logic [NUM_OUT-1:0] w_out_we;
    logic               w_wr_ok;
    logic [DATA_W-1:0]  w_rd_a;
    logic [DATA_W-1:0]  w_rd_b;

    logic [DATA_W-1:0]  r_w;
    logic [DATA_W-1:0]  r_data_a;
    logic [DATA_W-1:0]  r_data_b;
    logic [NUM_OUT-1:0] r_out_stb;
    logic               r_illegal;

    genvar c, i, k;

    for (c = 0; c < c_codes; c++) begin : g_code
        assign w_legal[c] = (c < NUM_GPR) || ((c >= c_out_base) && (c < c_end)) || (c == W_CODE);
        if (c == W_CODE) begin : g_w
            assign w_rd_tbl[c] = r_w;
        end else if (c >= c_end) begin : g_zero
            assign w_rd_tbl[c] = '0;
        end
    end

    for (i = 0; i < NUM_GPR; i++) begin : g_gpr
        logic              w_we;
        logic [DATA_W-1:0] r_q;
        assign w_we = wr_en && (Sel_C == SEL_W'(i));
        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset)   r_q <= '0;
            else if (w_we) r_q <= Data_C;
        end
        assign w_rd_tbl[i] = r_q;
    end

    for (k = 0; k < NUM_IN; k++) begin : g_in
        logic [DATA_W-1:0] r_sync1;
        logic [DATA_W-1:0] r_sync2;
        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                r_sync1 <= '0;
                r_sync2 <= '0;
            end else begin
                r_sync1 <= Input_Port[k*DATA_W +: DATA_W];
                r_sync2 <= r_sync1;
            end
        end
        assign w_rd_tbl[c_in_base + k] = r_sync2;
    end

    for (k = 0; k < NUM_OUT; k++) begin : g_out
        logic              w_we;
        logic [DATA_W-1:0] r_q;
        assign w_we        = wr_en && (Sel_C == SEL_W'(c_out_base + k));
        assign w_out_we[k] = w_we;
        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset)   r_q <= '0;
            else if (w_we) r_q <= Data_C;
        end
        assign w_rd_tbl[c_out_base + k]        = r_q;
        assign Output_Port[k*DATA_W +: DATA_W] = r_q;
    end

    // A write to W under MR is legal but loses to W_IN; it never flags an error.
    assign w_wr_ok = wr_en && w_legal[Sel_C];

    assign w_rd_a = (MR && (Sel_A == c_w_sel)) ? W_IN :
                    (w_wr_ok && (Sel_A == Sel_C)) ? Data_C : w_rd_tbl[Sel_A];
    assign w_rd_b = (MR && (Sel_B == c_w_sel)) ? W_IN :
                    (w_wr_ok && (Sel_B == Sel_C)) ? Data_C : w_rd_tbl[Sel_B];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_w       <= '0;
            r_data_a  <= '0;
            r_data_b  <= '0;
            r_out_stb <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (MR)
                r_w <= W_IN;
            else if (wr_en && (Sel_C == c_w_sel))
                r_w <= Data_C;
            if (rd_en) begin
                r_data_a <= w_rd_a;
                r_data_b <= w_rd_b;
            end
            r_out_stb <= w_out_we;
            if (wr_en && !w_legal[Sel_C])
                r_illegal <= 1'b1;
        end
    end

    assign Data_A      = r_data_a;
    assign Data_B      = r_data_b;
    assign Working_Reg = r_w;
    assign out_stb     = r_out_stb;
    assign illegal_wr  = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_register_bank_p.sv
// ============================================================================
//  Module      : tb_register_bank_p
//  Description : Scoreboard bench for register_bank_p against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_bank_p;

    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            nreset = 1'b0;
    logic [5:0]      Sel_A = '0, Sel_B = '0, Sel_C = '0;
    logic            rd_en = 1'b0, wr_en = 1'b0, MR = 1'b0;
    logic [DW-1:0]   Data_C = '0, W_IN = '0;
    logic [2*DW-1:0] Input_Port = '0;
    logic [DW-1:0]   Data_A, Data_B, Working_Reg;
    logic [2*DW-1:0] Output_Port;
    logic [1:0]      out_stb;
    logic            illegal_wr;

    register_bank_p dut (
        .clk(clk), .nreset(nreset),
        .Sel_A(Sel_A), .Sel_B(Sel_B), .rd_en(rd_en),
        .Sel_C(Sel_C), .Data_C(Data_C), .wr_en(wr_en),
        .MR(MR), .W_IN(W_IN), .Input_Port(Input_Port),
        .Data_A(Data_A), .Data_B(Data_B), .Output_Port(Output_Port),
        .Working_Reg(Working_Reg), .out_stb(out_stb), .illegal_wr(illegal_wr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]   a, b, w;
        logic [2*DW-1:0] op;
        logic [1:0]      stb;
        logic            ill;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state: registers by code, plus input history two edges deep.
    logic [DW-1:0] m_gpr [28];
    logic [DW-1:0] m_out [2];
    logic [DW-1:0] m_w, m_a, m_b;
    logic [DW-1:0] m_s1 [2];
    logic [DW-1:0] m_s2 [2];
    logic          m_ill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input int code);
        return (code < 28) || (code == 30) || (code == 31) || (code == 34);
    endfunction

    function automatic logic [DW-1:0] m_value(input int code);
        if (code < 28)                 return m_gpr[code];
        if (code == 28 || code == 29)  return m_s2[code-28];
        if (code == 30 || code == 31)  return m_out[code-30];
        if (code == 34)                return m_w;
        return '0;
    endfunction

    function automatic logic [DW-1:0] m_read(input int code, input logic wr, input int sc,
                                             input logic [DW-1:0] dc, input logic mr,
                                             input logic [DW-1:0] win);
        if (mr && code == 34)                  return win;
        if (wr && is_legal(sc) && code == sc)  return dc;
        return m_value(code);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 28; i++) m_gpr[i] = '0;
        for (int i = 0; i < 2; i++) begin
            m_out[i] = '0; m_s1[i] = '0; m_s2[i] = '0;
        end
        m_w = '0; m_a = '0; m_b = '0; m_ill = 1'b0;
    endtask

    task automatic step(input logic rd, input int sa, input int sb, input logic wr, input int sc,
                        input logic [DW-1:0] dc, input logic mr, input logic [DW-1:0] win,
                        input logic [2*DW-1:0] inp);
        exp_t e;
        logic [1:0] stb;
        @(negedge clk);
        rd_en = rd; Sel_A = 6'(sa); Sel_B = 6'(sb);
        wr_en = wr; Sel_C = 6'(sc); Data_C = dc;
        MR = mr; W_IN = win; Input_Port = inp;
        if (rd) begin
            m_a = m_read(sa, wr, sc, dc, mr, win);
            m_b = m_read(sb, wr, sc, dc, mr, win);
        end
        stb = 2'b00;
        if (wr) begin
            if (sc < 28)                     m_gpr[sc] = dc;
            else if (sc == 30 || sc == 31) begin
                m_out[sc-30] = dc;
                stb[sc-30]   = 1'b1;
            end else if (sc == 34)           m_w = dc;
            else                             m_ill = 1'b1;
        end
        if (mr) m_w = win;
        m_s2 = m_s1;
        m_s1[0] = inp[DW-1:0];
        m_s1[1] = inp[2*DW-1:DW];
        e.a = m_a; e.b = m_b; e.w = m_w;
        e.op = {m_out[1], m_out[0]};
        e.stb = stb; e.ill = m_ill;
        q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle(input logic [2*DW-1:0] inp);
        step(0, 0, 0, 0, 0, '0, 0, '0, inp);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_data_a"}, 32'(Data_A), 32'h0);
        chk({tag, "_data_b"}, 32'(Data_B), 32'h0);
        chk({tag, "_w"},      32'(Working_Reg), 32'h0);
        chk({tag, "_outp"},   Output_Port, 32'h0);
        chk({tag, "_stb"},    32'(out_stb), 32'h0);
        chk({tag, "_ill"},    32'(illegal_wr), 32'h0);
    endtask

    // Monitor: every edge after reset, the DUT presents its state; compare with the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("data_a",   32'(Data_A), 32'(e.a));
                chk("data_b",   32'(Data_B), 32'(e.b));
                chk("work_reg", 32'(Working_Reg), 32'(e.w));
                chk("out_port", Output_Port, e.op);
                chk("out_stb",  32'(out_stb), 32'(e.stb));
                chk("ill_wr",   32'(illegal_wr), 32'(e.ill));
            end
        end
    end

    function automatic int pick_code();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return int'($urandom_range(0, 63));
        if (r < 3)  return 34;
        if (r < 5)  return int'($urandom_range(28, 31));
        return int'($urandom_range(0, 35));
    endfunction

    logic [2*DW-1:0] inp;

    initial begin
        m_reset();
        inp = '0;
        #22;
        check_zero("reset");
        @(negedge clk);
        nreset = 1'b1;

        // Write then read back GPR 5.
        step(0, 0, 0, 1, 5, 16'h1234, 0, '0, inp);
        step(1, 5, 0, 0, 0, '0, 0, '0, inp);
        idle(inp);
        // Same-cycle write/read bypass on GPR 7.
        step(1, 0, 7, 1, 7, 16'hBEEF, 0, '0, inp);
        idle(inp);
        // MR beats a write to W, no error flag.
        step(1, 34, 34, 1, 34, 16'h5555, 1, 16'h00AA, inp);
        idle(inp);
        // Output port 0 strobe, then a same-value rewrite.
        step(0, 0, 0, 1, 30, 16'h0F0F, 0, '0, inp);
        step(1, 30, 31, 1, 30, 16'h0F0F, 0, '0, inp);
        idle(inp);
        // Input port 1 through the synchroniser.
        inp[2*DW-1:DW] = 16'hCAFE;
        for (int n = 0; n < 4; n++) step(1, 29, 28, 0, 0, '0, 0, '0, inp);
        // Writes to an input port and to an undefined code are ignored and flagged.
        step(1, 28, 28, 1, 28, 16'hDEAD, 0, '0, inp);
        step(1, 28, 33, 1, 33, 16'hDEAD, 0, '0, inp);
        idle(inp);

        // Mid-operation reset with a write in flight.
        @(negedge clk);
        wr_en = 1'b1; Sel_C = 6'd5; Data_C = 16'h7777; rd_en = 1'b1; Sel_A = 6'd5;
        #2 nreset = 1'b0;
        #1 check_zero("midrst");
        q.delete();
        m_reset();
        repeat (2) @(posedge clk);
        #1 check_zero("midrst_hold");
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        nreset = 1'b1;
        step(1, 5, 31, 1, 31, 16'h4321, 0, '0, inp);
        step(1, 31, 5, 0, 0, '0, 0, '0, inp);

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 5) == 0) inp = {$urandom()};
            step(1'($urandom_range(0, 1)), pick_code(), pick_code(),
                 1'($urandom_range(0, 1)), pick_code(), 16'($urandom()),
                 ($urandom_range(0, 4) == 0), 16'($urandom()), inp);
        end

        @(negedge clk);
        wr_en = 1'b0; MR = 1'b0; rd_en = 1'b0;
        @(posedge clk);
        #3;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
